// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: skid-buffer state encoding, default widths and
// per-boundary payload widths for the stage registers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_CNT_WIDTH = 16;

  localparam int PC_W       = 32;
  localparam int INSTR_W    = 32;
  localparam int DATA_W     = 32;
  localparam int FUNCT_W    = 6;
  localparam int SHAMT_W    = 5;
  localparam int REG_ADDR_W = 5;

  // Boundary payloads are the stage fields concatenated into one vector.
  localparam int IF_ID_W  = PC_W + INSTR_W;
  localparam int ID_EX_W  = 2 * DATA_W + FUNCT_W + SHAMT_W + 3 * REG_ADDR_W;
  localparam int EX_MEM_W = 2 * DATA_W + REG_ADDR_W;
  localparam int MEM_WB_W = DATA_W + REG_ADDR_W;

endpackage

// File: rtl/pipeline_skid_deliver_if.sv
// Stage-boundary handshake bundle: upstream (in_*) and downstream (out_*) sides.
// A beat transfers on a rising edge where valid and ready are both high; a
// producer holds valid and data stable until that edge, and ready never
// depends combinationally on valid.
interface pipeline_skid_deliver_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipeline_skid_deliver_sat_counter.sv
// Saturating event counter with synchronous clear; shared by the
// performance-monitor counters.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_skid_deliver.sv
// Two-entry (main + skid) stage register with registered upstream ready, flush,
// and a saturating back-pressure cycle counter.
module pipeline_skid_deliver
  import pipeline_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       cnt_clr,
  pipeline_skid_deliver_if.slave     bus,
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output skid_state_e                state_dbg
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any concurrent in_fire is dropped; an out_fire was still taken downstream.
      state_d = EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = bus.in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = RESET_VALUE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = RESET_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = RESET_VALUE;
          skid_d  = RESET_VALUE;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they leave as flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign state_dbg     = state_q;

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid_q & ~bus.out_ready),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_skid_deliver.sv
// Directed bench for pipeline_skid_deliver: driver tasks push payloads into an
// expected queue, a negedge monitor pops and compares on every output beat.
module tb_pipeline_skid_deliver;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        cnt_clr;
  logic [3:0]  stall_cnt;
  skid_state_e state_dbg;
  logic        mon_en;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  pipeline_skid_deliver_if #(.WIDTH(32)) bus ();

  pipeline_skid_deliver #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0),
    .CNT_WIDTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .bus      (bus),
    .stall_cnt(stall_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until accepted; returns cycles spent waiting on in_ready.
  task automatic push(input logic [31:0] d, output int waits);
    logic accepted;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 50; t++) begin
      accepted = bus.in_ready;
      tick();
      if (accepted) begin
        exp_q.push_back(d);
        bus.in_valid = 1'b0;
        return;
      end
      waits++;
    end
    bus.in_valid = 1'b0;
    check("push_timeout", 32'(waits), 32'd0);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 50; t++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst && !flush) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", bus.out_data);
        end else begin
          check("scoreboard", bus.out_data, exp_q.pop_front());
        end
      end else if (!bus.out_valid) begin
        check("bubble_data", bus.out_data, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    checks        = 0;
    errors        = 0;
    mon_en        = 1'b0;
    rst           = 1'b1;
    flush         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b0;

    // Reset with a live input: nothing may be captured.
    repeat (2) tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    mon_en       = 1'b1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  bus.out_data,       32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_stall_cnt", 32'(stall_cnt),     32'd0);
    check("rst_state",     32'(state_dbg),     32'(EMPTY));

    // Streaming at full rate.
    bus.out_ready = 1'b1;
    push(32'h1, w);
    check("stream1_wait", 32'(w), 32'd0);
    check("stream1_data", bus.out_data, 32'h1);
    check("stream1_rdy",  32'(bus.in_ready), 32'd1);
    push(32'h2, w);
    check("stream2_wait", 32'(w), 32'd0);
    check("stream2_data", bus.out_data, 32'h2);
    check("stream2_rdy",  32'(bus.in_ready), 32'd1);
    push(32'h3, w);
    check("stream3_wait", 32'(w), 32'd0);
    check("stream3_data", bus.out_data, 32'h3);
    drain("stream_drain");

    // Back-pressure: A in main, B in skid, C held upstream.
    bus.out_ready = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    push(32'hA, w);
    push(32'hB, w);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_state_full",   32'(state_dbg),    32'(FULL));
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hC;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_data",  bus.out_data,      32'hA);
    end
    // One stall edge for B's capture plus three held edges.
    check("bp_stall_cnt", 32'(stall_cnt), 32'd4);
    bus.out_ready = 1'b1;
    push(32'hC, w);
    check("bp_c_wait", 32'(w), 32'd1);
    drain("bp_drain");

    // Flush while FULL with a pending input that must vanish.
    bus.out_ready = 1'b0;
    push(32'h11, w);
    push(32'h22, w);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55;
    flush        = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_out_data",  bus.out_data,       32'h0);
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("flush_quiet", 32'(exp_q.size()), 32'd0);

    // Counter saturation at 15 with CNT_WIDTH=4, then clear and resume.
    bus.out_ready = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    push(32'h99, w);
    repeat (20) tick();
    check("sat_cnt", 32'(stall_cnt), 32'd15);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr", 32'(stall_cnt), 32'd0);
    tick();
    check("sat_resume", 32'(stall_cnt), 32'd1);
    bus.out_ready = 1'b1;
    drain("sat_drain");

    // Reset in FULL with downstream ready: both entries are lost.
    bus.out_ready = 1'b0;
    push(32'h7, w);
    push(32'h8, w);
    check("mid_state_full", 32'(state_dbg), 32'(FULL));
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    check("mid_rst_data",     bus.out_data,       32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
    check("mid_rst_state",    32'(state_dbg),     32'(EMPTY));
    repeat (5) tick();
    push(32'h33, w);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
